// File: rtl/ar_rx_decoder.sv
// ar_rx_decoder: bipolar RZ two-wire receiver recovering 32-bit address/data/parity words.
module ar_rx_decoder #(
  parameter int CLK_HZ = 50_000_000,
  parameter int R_VEL0 = 12_500,
  parameter int R_VEL1 = 50_000,
  parameter int R_VEL2 = 100_000,
  parameter int R_VEL3 = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Nvel,
  input  logic        Inp0,
  input  logic        Inp1,
  output logic [7:0]  ADR,
  output logic [22:0] DAT,
  output logic        ok_par,
  output logic        ce_wr,
  output logic        err_frm,
  output logic        busy
);
  localparam logic [15:0] BT0 = 16'(CLK_HZ / R_VEL0);
  localparam logic [15:0] BT1 = 16'(CLK_HZ / R_VEL1);
  localparam logic [15:0] BT2 = 16'(CLK_HZ / R_VEL2);
  localparam logic [15:0] BT3 = 16'(CLK_HZ / R_VEL3);

  typedef enum logic [2:0] {IDLE, PULSE, NUL, DONE, ERR} state_t;
  state_t st_q, st_d;

  logic [1:0]  s0_q, s1_q;
  logic        lp_q, ln_q;
  logic [15:0] bt_q, h_q, t_q;
  logic [4:0]  bc_q;
  logic [31:0] sh_q;
  logic [7:0]  adr_q;
  logic [22:0] dat_q;
  logic        par_q;

  logic        a0, a1, line, rise, both, acc, take;
  logic [15:0] bt_sel, q4, tmo;
  logic [31:0] sh_n;
  logic [22:0] dat_n;

  assign a0     = s0_q[1];
  assign a1     = s1_q[1];
  assign line   = a0 | a1;
  assign rise   = line & ~lp_q;
  assign both   = a0 & a1;
  assign bt_sel = Nvel == 2'd0 ? BT0 : Nvel == 2'd1 ? BT1 : Nvel == 2'd2 ? BT2 : BT3;
  assign q4     = bt_q >> 2;
  assign tmo    = bt_q + (bt_q >> 1);
  assign acc    = h_q >= q4;
  assign take   = st_q == PULSE && !line && acc;
  assign sh_n   = {sh_q[30:0], ln_q};

  // first DAT bit on the wire sits just below the address byte
  for (genvar i = 0; i < 23; i++) begin : g_rev
    assign dat_n[i] = sh_n[23-i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = rise ? PULSE : IDLE;
      PULSE:   st_d = both ? ERR
                    : line ? ((bc_q != 5'd0 && h_q >= tmo) ? ERR : PULSE)
                    : !acc ? (bc_q == 5'd0 ? IDLE : NUL)
                    : bc_q == 5'd31 ? DONE : NUL;
      NUL:     st_d = both ? ERR : t_q >= tmo ? ERR : rise ? PULSE : NUL;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    ce_wr   = st_q == DONE;
    err_frm = st_q == ERR;
    busy    = st_q == PULSE || st_q == NUL;
    ADR     = adr_q;
    DAT     = dat_q;
    ok_par  = par_q;
  end

  // t_q counts cycles since the last accepted bit's synchronised rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      lp_q  <= 1'b0;
      ln_q  <= 1'b0;
      bt_q  <= '0;
      h_q   <= '0;
      t_q   <= '0;
      bc_q  <= '0;
      sh_q  <= '0;
      adr_q <= '0;
      dat_q <= '0;
      par_q <= 1'b0;
    end else begin
      s0_q <= {s0_q[0], Inp0};
      s1_q <= {s1_q[0], Inp1};
      lp_q <= line;
      if (st_q == IDLE && rise) begin
        bt_q <= bt_sel;
        bc_q <= '0;
      end
      if (rise && (st_q == IDLE || st_q == NUL)) begin
        h_q  <= 16'd1;
        ln_q <= a1;
      end else if (st_q == PULSE && h_q != 16'hFFFF) h_q <= h_q + 16'd1;
      if (take) t_q <= h_q + 16'd2;
      else if (st_q != IDLE && t_q != 16'hFFFF) t_q <= t_q + 16'd1;
      if (take) begin
        sh_q <= sh_n;
        bc_q <= bc_q + 5'd1;
      end
      if (st_d == DONE) begin
        adr_q <= sh_n[31:24];
        dat_q <= dat_n;
        par_q <= ^sh_n;
      end
    end
  end
endmodule
